// File: rtl/ride_safety_fsm_mc.sv
// ride_safety_fsm_mc: multi-channel ride safety supervisor with debounce, escalation and acknowledged recovery.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   sensor_raw        raw per-channel hazard levels (1 = hazard)
//   mask              per-channel ignore bits (1 = ignored)
//   ack               operator acknowledge, honoured only in SHUTDOWN with no active flag
//   state             0 NORMAL, 1 WARNING, 2 FAULT, 3 SHUTDOWN, 4 RECOVERY
//   alarm             high whenever state != NORMAL
//   fault_code        lowest active flag index + 1, 0 when no flag is active
//   fault_latched     sticky record of flagged channels, cleared on RECOVERY -> NORMAL
// Optional macro RIDE_FSM_MASK_LOCK_EN: outside NORMAL, flags use a mask shadow frozen on leaving NORMAL.
module ride_safety_fsm_mc #(
    parameter int                NUM_CH           = 8,
    parameter int                DEBOUNCE_CYCLES  = 3,
    parameter int                PERSIST_CYCLES   = 5,
    parameter int                SHUTDOWN_TIMEOUT = 20,
    parameter int                RECOVER_CYCLES   = 8,
    parameter logic [NUM_CH-1:0] CRIT_MASK        = NUM_CH'('h03),
    parameter logic [NUM_CH-1:0] KILL_MASK        = NUM_CH'('h01)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           sensor_raw,
    input  logic [NUM_CH-1:0]           mask,
    input  logic                        ack,
    output logic [2:0]                  state,
    output logic                        alarm,
    output logic [$clog2(NUM_CH+1)-1:0] fault_code,
    output logic [NUM_CH-1:0]           fault_latched
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(SHUTDOWN_TIMEOUT + 1);
    localparam int RW = $clog2(RECOVER_CYCLES + 1);
    localparam int FW = $clog2(NUM_CH + 1);

    typedef enum logic [2:0] {
        NORMAL   = 3'd0,
        WARNING  = 3'd1,
        FAULT    = 3'd2,
        SHUTDOWN = 3'd3,
        RECOVERY = 3'd4
    } state_t;

    state_t                   state_q, state_d, cur;
    logic [NUM_CH-1:0]        db_q, db_d;
    logic [NUM_CH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0]            persist_q, persist_d, persist_inc;
    logic [RW-1:0]            rec_q, rec_d;
    logic [NUM_CH-1:0]        fault_latched_q, fault_latched_d;
    logic [NUM_CH-1:0]        mask_eff, flag;
    logic                     any, crit, kill;

    // Encodings 5..7 cannot be reached; treat them as SHUTDOWN so a corrupted register fails safe.
    assign cur = (state_q > RECOVERY) ? SHUTDOWN : state_q;

`ifdef RIDE_FSM_MASK_LOCK_EN
    logic [NUM_CH-1:0] mask_sh_q, mask_sh_d;
    assign mask_sh_d = (cur == NORMAL) ? mask : mask_sh_q;
    assign mask_eff  = (cur == NORMAL) ? mask : mask_sh_q;
    always_ff @(posedge clk) begin
        mask_sh_q <= rst ? '0 : mask_sh_d;
    end
`else
    assign mask_eff = mask;
`endif

    assign flag = db_q & ~mask_eff;
    assign any  = |flag;
    assign crit = |(flag & CRIT_MASK);
    assign kill = |(flag & KILL_MASK);

    always_comb begin
        fault_code = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (flag[i]) fault_code = FW'(i + 1);
    end

    // Debounce: a channel's bit follows raw only after DEBOUNCE_CYCLES consecutive differing cycles.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (sensor_raw[i] != db_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) db_d[i] = sensor_raw[i];
                else cnt_d[i] = cnt_q[i] + CW'(1);
            end
    end

    always_comb begin
        persist_inc     = (persist_q == PW'(SHUTDOWN_TIMEOUT)) ? persist_q : persist_q + PW'(1);
        state_d         = cur;
        persist_d       = '0;
        rec_d           = '0;
        fault_latched_d = fault_latched_q | flag;
        case (cur)
            NORMAL: begin
                state_d   = any ? WARNING : NORMAL;
                persist_d = any ? PW'(1) : '0;
            end
            WARNING: begin
                persist_d = any ? persist_inc : '0;
                state_d   = (crit || persist_q >= PW'(PERSIST_CYCLES)) ? FAULT : (!any ? NORMAL : WARNING);
            end
            FAULT: begin
                persist_d = any ? persist_inc : '0;
                state_d   = (kill || persist_q >= PW'(SHUTDOWN_TIMEOUT)) ? SHUTDOWN : (!any ? WARNING : FAULT);
            end
            RECOVERY: begin
                state_d         = any ? SHUTDOWN : ((rec_q == RW'(RECOVER_CYCLES - 1)) ? NORMAL : RECOVERY);
                rec_d           = (any || rec_q == RW'(RECOVER_CYCLES - 1)) ? '0 : rec_q + RW'(1);
                fault_latched_d = (!any && rec_q == RW'(RECOVER_CYCLES - 1)) ? '0 : fault_latched_q | flag;
            end
            default: state_d = (ack && !any) ? RECOVERY : SHUTDOWN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= NORMAL;
            db_q            <= '0;
            cnt_q           <= '0;
            persist_q       <= '0;
            rec_q           <= '0;
            fault_latched_q <= '0;
        end else begin
            state_q         <= state_d;
            db_q            <= db_d;
            cnt_q           <= cnt_d;
            persist_q       <= persist_d;
            rec_q           <= rec_d;
            fault_latched_q <= fault_latched_d;
        end
    end

    assign state         = cur;
    assign alarm         = (cur != NORMAL);
    assign fault_latched = fault_latched_q;
endmodule

// File: tb/tb_ride_safety_fsm_mc.sv
// tb_ride_safety_fsm_mc: directed table, corner sequences and randomized model comparison for ride_safety_fsm_mc.
module tb_ride_safety_fsm_mc;
    localparam int DB = 3;
    localparam int PC = 5;
    localparam int TO = 20;
    localparam int RC = 8;
    localparam logic [7:0] CRIT = 8'h03;
    localparam logic [7:0] KILL = 8'h01;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sensor_raw = '0;
    logic [7:0] mask = '0;
    logic       ack = 1'b0;
    logic [2:0] state;
    logic       alarm;
    logic [3:0] fault_code;
    logic [7:0] fault_latched;

    int checks = 0;
    int failures = 0;

    ride_safety_fsm_mc dut (
        .clk(clk), .rst(rst), .sensor_raw(sensor_raw), .mask(mask), .ack(ack),
        .state(state), .alarm(alarm), .fault_code(fault_code), .fault_latched(fault_latched)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [7:0] raw;
        logic [7:0] msk;
        logic       a;
        int         n;
        int         st;
        int         code;
        logic [7:0] lat;
    } vec_t;
    vec_t vecs[$];

    int         m_st, m_pers, m_rec;
    logic [7:0] m_db, m_lat, m_sh;
    int         m_run[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_flags();
`ifdef RIDE_FSM_MASK_LOCK_EN
        return m_db & ~((m_st == 0) ? mask : m_sh);
`else
        return m_db & ~mask;
`endif
    endfunction

    function automatic int m_code();
        logic [7:0] f = m_flags();
        for (int i = 0; i < 8; i++)
            if (f[i]) return i + 1;
        return 0;
    endfunction

    task automatic model_step();
        logic [7:0] f;
        bit any, crit, kill;
        int ns, np, nr;
        if (rst) begin
            m_st = 0; m_pers = 0; m_rec = 0; m_db = '0; m_lat = '0; m_sh = '0;
            for (int i = 0; i < 8; i++) m_run[i] = 0;
        end else begin
            f = m_flags();
            any = (f != 0);
            crit = ((f & CRIT) != 0);
            kill = ((f & KILL) != 0);
            ns = m_st; np = 0; nr = 0;
            if (m_st == 0) begin
                if (any) begin ns = 1; np = 1; end
            end else if (m_st == 1 || m_st == 2) begin
                np = any ? ((m_pers + 1 > TO) ? TO : m_pers + 1) : 0;
                if (m_st == 1) ns = (crit || m_pers >= PC) ? 2 : (any ? 1 : 0);
                else ns = (kill || m_pers >= TO) ? 3 : (any ? 2 : 1);
            end else if (m_st == 3) begin
                ns = (ack && !any) ? 4 : 3;
            end else begin
                if (any) ns = 3;
                else if (m_rec == RC - 1) ns = 0;
                else nr = m_rec + 1;
            end
            m_lat = (m_st == 4 && ns == 0) ? 8'h00 : (m_lat | f);
            if (m_st == 0) m_sh = mask;
            for (int i = 0; i < 8; i++) begin
                if (sensor_raw[i] == m_db[i]) m_run[i] = 0;
                else begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin m_db[i] = sensor_raw[i]; m_run[i] = 0; end
                end
            end
            m_st = ns; m_pers = np; m_rec = nr;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic r, input logic [7:0] raw, input logic [7:0] msk, input logic a,
                                input int n, input int st, input int code, input logic [7:0] lat);
        vec_t v;
        v.r = r; v.raw = raw; v.msk = msk; v.a = a; v.n = n; v.st = st; v.code = code; v.lat = lat;
        vecs.push_back(v);
    endfunction

    initial begin
        add(0, 8'h20, 8'h00, 0,  2, 0, 0, 8'h00);
        add(0, 8'h00, 8'h00, 0,  3, 0, 0, 8'h00);
        add(0, 8'h20, 8'h00, 0,  3, 0, 6, 8'h00);
        add(0, 8'h20, 8'h00, 0,  1, 1, 6, 8'h20);
        add(0, 8'h20, 8'h00, 0,  4, 1, 6, 8'h20);
        add(0, 8'h20, 8'h00, 0,  1, 2, 6, 8'h20);
        add(0, 8'h20, 8'h00, 0, 14, 2, 6, 8'h20);
        add(0, 8'h20, 8'h00, 0,  1, 3, 6, 8'h20);
        add(0, 8'h20, 8'h00, 1,  2, 3, 6, 8'h20);
        add(0, 8'h00, 8'h00, 0,  2, 3, 6, 8'h20);
        add(0, 8'h00, 8'h00, 0,  1, 3, 0, 8'h20);
        add(0, 8'h00, 8'h00, 1,  1, 4, 0, 8'h20);
        add(0, 8'h00, 8'h00, 0,  7, 4, 0, 8'h20);
        add(0, 8'h00, 8'h00, 0,  1, 0, 0, 8'h00);
        add(0, 8'h01, 8'h00, 0,  3, 0, 1, 8'h00);
        add(0, 8'h01, 8'h00, 0,  1, 1, 1, 8'h01);
        add(0, 8'h01, 8'h00, 0,  1, 2, 1, 8'h01);
        add(0, 8'h01, 8'h00, 0,  1, 3, 1, 8'h01);
        add(0, 8'h01, 8'h00, 1,  2, 3, 1, 8'h01);
        add(0, 8'h00, 8'h00, 0,  3, 3, 0, 8'h01);
        add(0, 8'h00, 8'h00, 1,  1, 4, 0, 8'h01);
        add(0, 8'h00, 8'h00, 0,  2, 4, 0, 8'h01);
        add(0, 8'h08, 8'h00, 0,  3, 4, 4, 8'h01);
        add(0, 8'h08, 8'h00, 0,  1, 3, 4, 8'h09);
        add(0, 8'h00, 8'h00, 0,  3, 3, 0, 8'h09);
        add(0, 8'h00, 8'h00, 1,  1, 4, 0, 8'h09);
        add(0, 8'h00, 8'h00, 0,  7, 4, 0, 8'h09);
        add(0, 8'h00, 8'h00, 0,  1, 0, 0, 8'h00);
        add(0, 8'h20, 8'h00, 0,  4, 1, 6, 8'h20);
        add(0, 8'h20, 8'h00, 0,  7, 2, 6, 8'h20);
        add(1, 8'h20, 8'h00, 0,  1, 0, 0, 8'h00);
        add(0, 8'h00, 8'h00, 0,  3, 0, 0, 8'h00);

        rst = 1'b1;
        tick();
        chk("reset_state", state, 0);
        chk("reset_alarm", alarm, 0);
        chk("reset_code", fault_code, 0);
        chk("reset_latched", fault_latched, 0);
        rst = 1'b0;

        for (int v = 0; v < vecs.size(); v++) begin
            rst = vecs[v].r; sensor_raw = vecs[v].raw; mask = vecs[v].msk; ack = vecs[v].a;
            for (int k = 0; k < vecs[v].n; k++) tick();
            chk($sformatf("vec%0d_state", v), state, vecs[v].st);
            chk($sformatf("vec%0d_alarm", v), alarm, (vecs[v].st != 0) ? 1 : 0);
            chk($sformatf("vec%0d_code", v), fault_code, vecs[v].code);
            chk($sformatf("vec%0d_latched", v), fault_latched, vecs[v].lat);
        end
        rst = 1'b0; ack = 1'b0;

        sensor_raw = 8'h12; mask = 8'h00;
        repeat (3) tick();
        chk("prio_code_ch1", fault_code, 2);
        chk("prio_state", state, 0);
        mask = 8'h02;
        #1;
        chk("masked_code_ch4", fault_code, 5);
        mask = 8'h00;
        tick();
        chk("prio_warn", state, 1);
        tick();
        chk("prio_fault", state, 2);
        mask = 8'h02;
        #1;
`ifdef RIDE_FSM_MASK_LOCK_EN
        chk("lock_code", fault_code, 2);
`else
        chk("live_mask_code", fault_code, 5);
`endif
        tick();
        chk("fault_hold", state, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0; mask = 8'h00; sensor_raw = 8'h00;
        chk("midrst_state", state, 0);
        chk("midrst_code", fault_code, 0);
        chk("midrst_latched", fault_latched, 0);

        for (int c = 0; c < 4000; c++) begin
            int r = $urandom_range(0, 99);
            if (r < 4) sensor_raw = sensor_raw | (8'h01 << $urandom_range(0, 7));
            else if (r < 20) sensor_raw = sensor_raw & ~(8'h01 << $urandom_range(0, 7));
            else if (r < 23) sensor_raw = 8'h00;
            if ($urandom_range(0, 49) == 0) mask = 8'($urandom & $urandom);
            ack = ($urandom_range(0, 9) < 3);
            rst = ($urandom_range(0, 299) == 0);
            tick();
            chk("rnd_state", state, m_st);
            chk("rnd_alarm", alarm, (m_st != 0) ? 1 : 0);
            chk("rnd_code", fault_code, m_code());
            chk("rnd_latched", fault_latched, m_lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
